// File: rtl/num_classifier_seq.sv
// Sequential number classifier: one operand in flight, reports primality by
// iterative trial division and divisibility by 2, 3, 5, 7 and 11.
module num_classifier_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_prime,
    output logic [4:0]       out_mul
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned RW = WIDTH + 1;
    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned NM = 5;

    typedef enum logic [1:0] {IDLE, MUL, TRIAL, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [WIDTH-1:0]        n_q, n_d;
    logic [WIDTH-1:0]        sh_q, sh_d;
    logic [NM-1:0][RW-1:0]   rm_q, rm_d;
    logic [RW-1:0]           rt_q, rt_d;
    logic [WIDTH-1:0]        div_q, div_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_prime_q, out_prime_d;
    logic [4:0]              out_mul_q, out_mul_d;

    logic                    done_c;
    logic                    prime_c;
    logic [RW-1:0]           rt_step_c;
    logic [WIDTH-1:0]        div_nx_c;
    logic [4:0]              flags_c;

    // One MSB-first restoring remainder step: r <= 2r + b, minus d if it fits.
    function automatic logic [RW-1:0] rem_step(input logic [RW-1:0] r,
                                               input logic b,
                                               input logic [WIDTH-1:0] d);
        logic [RW-1:0] t;
        t = {r[WIDTH-1:0], b};
        if (t >= {1'b0, d}) begin
            t = t - {1'b0, d};
        end
        return t;
    endfunction

    // Constant divisors of the parallel divisibility units.
    function automatic logic [WIDTH-1:0] mul_div(input int unsigned i);
        logic [WIDTH-1:0] d;
        case (i)
            0:       d = WIDTH'(2);
            1:       d = WIDTH'(3);
            2:       d = WIDTH'(5);
            3:       d = WIDTH'(7);
            default: d = WIDTH'(11);
        endcase
        return d;
    endfunction

    // Trial-division bound: once d*d exceeds n, no smaller factor remains.
    function automatic logic sq_gt(input logic [WIDTH-1:0] d,
                                   input logic [WIDTH-1:0] n);
        logic [W2-1:0] dd;
        dd = W2'(d) * W2'(d);
        return dd > W2'(n);
    endfunction

    // Divisibility flags from the settled constant-divisor remainders.
    always_comb begin
        flags_c = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            flags_c[i] = (rm_q[i] == '0);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        n_d         = n_q;
        sh_d        = sh_q;
        rm_d        = rm_q;
        rt_d        = rt_q;
        div_d       = div_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_prime_d = out_prime_q;
        out_mul_d   = out_mul_q;
        done_c      = 1'b0;
        prime_c     = 1'b0;
        rt_step_c   = rem_step(rt_q, sh_q[WIDTH-1], div_q);
        div_nx_c    = WIDTH'(div_q + WIDTH'(2));

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready_q) begin
                    n_d        = in;
                    sh_d       = in;
                    cnt_d      = '0;
                    rm_d       = '0;
                    rt_d       = '0;
                    in_ready_d = 1'b0;
                    state_d    = MUL;
                end
            end
            MUL: begin
                if (cnt_q == CW'(WIDTH)) begin
                    // Remainders are final; classify the trivial cases here.
                    if (n_q < WIDTH'(2)) begin
                        done_c = 1'b1;
                    end else if (n_q == WIDTH'(2) || n_q == WIDTH'(3)) begin
                        done_c  = 1'b1;
                        prime_c = 1'b1;
                    end else if (!n_q[0]) begin
                        done_c = 1'b1;
                    end else begin
                        div_d = WIDTH'(3);
                        if (sq_gt(WIDTH'(3), n_q)) begin
                            done_c  = 1'b1;
                            prime_c = 1'b1;
                        end else begin
                            state_d = TRIAL;
                            cnt_d   = '0;
                            sh_d    = n_q;
                            rt_d    = '0;
                        end
                    end
                end else begin
                    for (int unsigned i = 0; i < NM; i++) begin
                        rm_d[i] = rem_step(rm_q[i], sh_q[WIDTH-1], mul_div(i));
                    end
                    sh_d  = sh_q << 1;
                    cnt_d = cnt_q + CW'(1);
                end
            end
            TRIAL: begin
                rt_d  = rt_step_c;
                sh_d  = sh_q << 1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    if (rt_step_c == '0) begin
                        done_c = 1'b1;
                    end else begin
                        div_d = div_nx_c;
                        if (sq_gt(div_nx_c, n_q)) begin
                            done_c  = 1'b1;
                            prime_c = 1'b1;
                        end else begin
                            cnt_d = '0;
                            sh_d  = n_q;
                            rt_d  = '0;
                        end
                    end
                end
            end
            DONE: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (done_c) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            out_prime_d = prime_c;
            out_mul_d   = flags_c;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            sh_q        <= '0;
            rm_q        <= '0;
            rt_q        <= '0;
            div_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_prime_q <= 1'b0;
            out_mul_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            n_q         <= n_d;
            sh_q        <= sh_d;
            rm_q        <= rm_d;
            rt_q        <= rt_d;
            div_q       <= div_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_prime_q <= out_prime_d;
            out_mul_q   <= out_mul_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prime = out_prime_q;
    assign out_mul   = out_mul_q;

endmodule

// File: doc/num_classifier_seq.md
Name: num_classifier_seq

Overview:
- Sequential, parametrised number classifier.
- Accepts an unsigned WIDTH-bit operand over a valid/ready handshake.
- Reports primality by iterative trial division, plus divisibility by 2, 3, 5, 7 and 11.
- Sits between an operand source and a result consumer. Both sides use independent valid/ready handshakes, and one operand is in flight at a time.

Parameters:
- WIDTH, 8, operand width in bits; legal range 4..16.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in  input  WIDTH  operand, unsigned.
- in_valid  input  1  operand valid.
- in_ready  output  1  block idle and able to accept an operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out_prime  output  1  1 when the operand is prime.
- out_mul  output  5  divisibility flags: [4]=11, [3]=7, [2]=5, [1]=3, [0]=2.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset_n=0:
  - state=IDLE; in_ready=0; out_valid=0; out_prime=0; out_mul=0; all datapath registers cleared.
  - Reset mid-operation discards the operand; no result is produced for it.
- in_ready is registered. It rises on the first clk edge after reset_n deasserts. It falls on the accept edge.
- Input handshake: an operand is accepted at the edge where in_valid & in_ready. in is captured into register N on that edge; the in value is ignored at all other times.
- States: IDLE, MUL, TRIAL, DONE.
- Bit-serial remainder step, per cycle, MSB first over WIDTH cycles:
  - r <= 2r + bit.
  - If the result is >= the divisor, subtract the divisor.
  - r is WIDTH+1 bits wide.
- MUL state (WIDTH cycles):
  - Five constant-divisor remainder units (2, 3, 5, 7, 11) run in parallel.
  - out_mul[i] = (remainder == 0); N=0 therefore sets all five flags.
- Decision at the end of MUL:
  - N<2 -> out_prime=0, go to DONE.
  - N=2 or N=3 -> out_prime=1, go to DONE.
  - N even -> out_prime=0, go to DONE.
  - Otherwise D=3, then apply the bound check.
- Bound check:
  - D*D > N (2*WIDTH-bit compare) -> out_prime=1, go to DONE.
  - Otherwise enter TRIAL.
- TRIAL state (WIDTH cycles per divisor):
  - Computes N mod D with the same serial step.
  - Remainder 0 -> out_prime=0, go to DONE.
  - Otherwise D <= D+2, then re-apply the bound check.
  - D is WIDTH bits wide and cannot overflow for legal WIDTH.
- Latency:
  - T = number of TRIAL passes executed.
  - out_valid rises WIDTH*(1+T)+1 edges after the accept edge.
- DONE state:
  - out_valid=1.
  - out_prime and out_mul are stable and held until the edge where out_valid & out_ready.
  - On that edge: out_valid<=0, in_ready<=1, state<=IDLE.
  - out_ready high before out_valid has no effect. out_ready low stalls indefinitely with no data change.
- Throughput: at most one operand in flight. in_valid is ignored while in_ready=0.
- out_prime and out_mul hold the last result after consumption until the next DONE overwrites them.

Test Plan:
- Reset: hold reset_n=0 with in_valid=1 -> in_ready=0, out_valid=0, outputs 0. Release reset -> in_ready=1 after one edge.
- WIDTH=8, N=7 (T=0) -> out_valid rises 9 edges after accept; out_prime=1; out_mul=5'b01000.
- WIDTH=8, N=77, out_ready=1 (T=3: D=3,5,7) -> latency 33; out_prime=0; out_mul=5'b11000. in_ready returns 1 the edge after the result is consumed.
- WIDTH=8, N=97 (T=4: D=3,5,7,9) -> latency 41; out_prime=1; out_mul=0. Hold out_ready=0 for 10 cycles -> out_valid and data remain stable until out_ready=1.
- Boundaries, WIDTH=8:
  - N=0 -> out_prime=0, out_mul=5'b11111, latency 9.
  - N=1 -> out_prime=0, out_mul=0.
  - N=2 -> out_prime=1, out_mul=5'b00001.
  - N=255 -> out_prime=0, out_mul=5'b00110, latency 17.
- Reset mid-TRIAL: assert reset_n=0 during N=97 processing -> outputs clear immediately and no out_valid follows. A new N=25 after reset -> out_prime=0, out_mul=5'b00100, latency 25.
